// File: rtl/cut_position_scheduler.sv
// Keyed 32-bit Galois LFSR producing one raw cut position per active line.
// Reseeded from the latched key at frame start so a descrambler can track it.
module cut_position_scheduler #(
  parameter int LFSR_WIDTH = 32,
  parameter int CUT_WIDTH = 8,
  parameter logic [LFSR_WIDTH-1:0] LFSR_TAPS = 32'h80200003,
  parameter int RESEED_EACH_FRAME = 1,
  parameter int LINE_IDX_WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic [LFSR_WIDTH-1:0]     key,
  input  logic                      key_load,
  input  logic                      H,
  input  logic                      V,
  input  logic                      F,
  output logic [CUT_WIDTH-1:0]      raw_cut_position,
  output logic [LINE_IDX_WIDTH-1:0] line_index,
  output logic                      frame_sync,
  output logic                      locked
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACTIVE
  } state_e;

  localparam logic [LFSR_WIDTH-1:0] ONE =
    {{(LFSR_WIDTH-1){1'b0}}, 1'b1};

  state_e                    state_q, state_d;
  logic [LFSR_WIDTH-1:0]     lfsr_q, lfsr_d;
  logic [LFSR_WIDTH-1:0]     key_q, key_d;
  logic                      kv_q, kv_d;
  logic [CUT_WIDTH-1:0]      cut_q, cut_d;
  logic [LINE_IDX_WIDTH-1:0] line_q, line_d;
  logic                      fs_q, fs_d;
  logic                      locked_q, locked_d;
  logic                      prev_h_q, prev_v_q, prev_f_q;
  logic                      h_rise, f_fall;
  logic [LFSR_WIDTH-1:0]     lfsr_step;

  assign h_rise = H & ~prev_h_q;
  assign f_fall = ~F & prev_f_q;
  assign lfsr_step = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS)
                               : (lfsr_q >> 1);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      lfsr_q   <= ONE;
      key_q    <= ONE;
      kv_q     <= 1'b0;
      cut_q    <= '0;
      line_q   <= '0;
      fs_q     <= 1'b0;
      locked_q <= 1'b0;
      prev_h_q <= 1'b0;
      prev_v_q <= 1'b0;
      prev_f_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      key_q    <= key_d;
      kv_q     <= kv_d;
      cut_q    <= cut_d;
      line_q   <= line_d;
      fs_q     <= fs_d;
      locked_q <= locked_d;
      prev_h_q <= H;
      prev_v_q <= V;
      prev_f_q <= F;
    end
  end

  // A key load re-arms the search for the next frame start.
  always_comb begin
    state_d = state_q;
    if (key_load) begin
      state_d = enable ? S_WAIT : S_IDLE;
    end else if (!enable) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:   if (kv_q) state_d = S_WAIT;
        S_WAIT:   if (f_fall) state_d = S_ACTIVE;
        S_ACTIVE: state_d = S_ACTIVE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    lfsr_d   = lfsr_q;
    key_d    = key_q;
    kv_d     = kv_q;
    cut_d    = cut_q;
    line_d   = line_q;
    fs_d     = 1'b0;
    locked_d = (state_d == S_ACTIVE);
    if (key_load) begin
      key_d = (key == '0) ? ONE : key;
      kv_d  = 1'b1;
    end
    if (key_load || !enable) begin
      cut_d = '0;
    end else begin
      unique case (state_q)
        S_WAIT: begin
          cut_d = '0;
          if (f_fall) begin
            lfsr_d = key_q;
            line_d = '0;
            fs_d   = 1'b1;
          end
        end
        S_ACTIVE: begin
          if (f_fall) begin
            line_d = '0;
            if (RESEED_EACH_FRAME != 0) begin
              lfsr_d = key_q;
              fs_d   = 1'b1;
            end
          end else if (h_rise && !V) begin
            cut_d  = lfsr_q[CUT_WIDTH-1:0];
            lfsr_d = lfsr_step;
            if (line_q != '1) line_d = line_q + 1'b1;
          end
        end
        default: cut_d = '0;
      endcase
    end
  end

  assign raw_cut_position = cut_q;
  assign line_index       = line_q;
  assign frame_sync       = fs_q;
  assign locked           = locked_q;

  logic unused_v;
  assign unused_v = prev_v_q;

endmodule

// File: tb/tb_cut_position_scheduler.sv
// Randomized and directed bench for cut_position_scheduler; two instances
// cover per-frame reseed and free-running sequences.
module tb_cut_position_scheduler;

  localparam logic [31:0] TAPS = 32'h80200003;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] key = '0;
  logic        key_load = 1'b0;
  logic        H = 1'b0, V = 1'b0, F = 1'b0;

  logic [7:0]  cut1, cut2;
  logic [9:0]  line1, line2;
  logic        fs1, fs2, lk1, lk2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cut_position_scheduler #(.RESEED_EACH_FRAME(1)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .key(key), .key_load(key_load),
    .H(H), .V(V), .F(F),
    .raw_cut_position(cut1), .line_index(line1),
    .frame_sync(fs1), .locked(lk1)
  );

  cut_position_scheduler #(.RESEED_EACH_FRAME(0)) dut_nr (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .key(key), .key_load(key_load),
    .H(H), .V(V), .F(F),
    .raw_cut_position(cut2), .line_index(line2),
    .frame_sync(fs2), .locked(lk2)
  );

  // Reference model: 0 idle, 1 waiting for frame, 2 running
  int          mode;
  logic [31:0] m_key, m_lfsr, m_lfsr2;
  bit          m_kv, m_fs, m_fs2;
  logic [7:0]  m_cut, m_cut2;
  logic [9:0]  m_line;
  bit          pH, pV, pF;

  function automatic logic [31:0] nxt(input logic [31:0] x);
    return x[0] ? ((x >> 1) ^ TAPS) : (x >> 1);
  endfunction

  function automatic logic [39:0] expv();
    return {m_cut, m_line, m_fs, mode == 2,
            m_cut2, m_line, m_fs2, mode == 2};
  endfunction

  wire [39:0] obs = {cut1, line1, fs1, lk1, cut2, line2, fs2, lk2};

  task automatic model_step();
    bit hr, ff;
    hr = H && !pH;
    ff = !F && pF;
    m_fs = 0;
    m_fs2 = 0;
    if (!reset_n) begin
      mode = 0; m_key = 1; m_kv = 0;
      m_lfsr = 1; m_lfsr2 = 1;
      m_cut = 0; m_cut2 = 0; m_line = 0;
      pH = 0; pV = 0; pF = 0;
      return;
    end
    if (key_load) begin
      m_key = (key == 0) ? 32'd1 : key;
      m_kv = 1;
      mode = enable ? 1 : 0;
      m_cut = 0; m_cut2 = 0;
    end else if (!enable) begin
      mode = 0; m_cut = 0; m_cut2 = 0;
    end else if (mode == 0) begin
      if (m_kv) mode = 1;
    end else if (mode == 1) begin
      if (ff) begin
        m_lfsr = m_key; m_lfsr2 = m_key;
        m_line = 0; m_fs = 1; m_fs2 = 1;
        mode = 2;
      end
    end else begin
      if (ff) begin
        m_line = 0; m_lfsr = m_key; m_fs = 1;
      end else if (hr && !V) begin
        m_cut = m_lfsr[7:0]; m_lfsr = nxt(m_lfsr);
        m_cut2 = m_lfsr2[7:0]; m_lfsr2 = nxt(m_lfsr2);
        if (m_line != 10'h3FF) m_line = m_line + 1;
      end
    end
    pH = H; pV = V; pF = F;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_line(input bit vb);
    V = vb; H = 1; tick();
    H = 0; tick();
  endtask

  task automatic frame_start();
    F = 1; tick();
    F = 0; tick();
  endtask

  task automatic load_key(input logic [31:0] k);
    key = k; key_load = 1; tick();
    key_load = 0; tick();
  endtask

  task automatic test_reset();
    reset_n = 0;
    for (int i = 0; i < 4; i++) begin
      H = i[0]; V = i[1]; F = ~i[0];
      tick();
    end
    checks++;
    if (obs !== 40'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=0", obs);
    end
    H = 0; V = 0; F = 0;
    reset_n = 1; enable = 1;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (cut1 !== 8'h00 || lk1 !== 1'b0 || obs !== expv()) begin
      failures++;
      $display("FAIL idle_no_key got=%h want=%h", obs, expv());
    end
  endtask

  task automatic test_keyed_sequence();
    logic [7:0] exp_cut [3];
    exp_cut[0] = 8'h2A; exp_cut[1] = 8'h15; exp_cut[2] = 8'h09;
    load_key(32'h0000002A);
    F = 1; tick();
    F = 0; tick();
    checks++;
    if (fs1 !== 1'b1 || obs !== expv()) begin
      failures++;
      $display("FAIL frame_sync got=%b want=1 (%h/%h)",
               fs1, obs, expv());
    end
    tick();
    checks++;
    if (lk1 !== 1'b1 || fs1 !== 1'b0) begin
      failures++;
      $display("FAIL locked got=%b fs=%b want=1/0", lk1, fs1);
    end
    for (int i = 0; i < 3; i++) begin
      V = 0; H = 1; tick();
      checks++;
      if (cut1 !== exp_cut[i] || line1 !== 10'(i + 1)
          || obs !== expv()) begin
        failures++;
        $display("FAIL line%0d cut=%h want=%h idx=%0d want=%0d",
                 i, cut1, exp_cut[i], line1, i + 1);
      end
      H = 0; tick();
    end
  endtask

  task automatic test_vblank();
    for (int i = 0; i < 5; i++) do_line(1);
    V = 0;
    checks++;
    if (cut1 !== 8'h09 || line1 !== 10'd3 || obs !== expv()) begin
      failures++;
      $display("FAIL vblank cut=%h idx=%0d want=09/3", cut1, line1);
    end
  endtask

  task automatic test_frame_reseed();
    int n;
    n = $urandom_range(1, 6);
    for (int i = 0; i < n; i++) do_line(0);
    frame_start();
    do_line(0);
    checks++;
    if (cut1 !== 8'h2A || line1 !== 10'd1 || obs !== expv()) begin
      failures++;
      $display("FAIL reseed cut=%h idx=%0d nr=%h want=2A/1/%h",
               cut1, line1, cut2, m_cut2);
    end
  endtask

  task automatic test_zero_key();
    load_key(32'h0);
    frame_start();
    do_line(0);
    checks++;
    if (cut1 !== 8'h01 || cut2 !== 8'h01 || obs !== expv()) begin
      failures++;
      $display("FAIL zero_key cut=%h want=01", cut1);
    end
  endtask

  task automatic test_enable_drop();
    load_key(32'h2A);
    frame_start();
    for (int i = 0; i < 9; i++) do_line(0);
    checks++;
    if (line1 !== 10'd9 || obs !== expv()) begin
      failures++;
      $display("FAIL pre_drop idx=%0d want=9", line1);
    end
    H = 1; enable = 0; tick();
    checks++;
    if (cut1 !== 8'h00 || lk1 !== 1'b0 || obs !== expv()) begin
      failures++;
      $display("FAIL drop cut=%h lk=%b want=0/0", cut1, lk1);
    end
    H = 0; tick();
    enable = 1;
    for (int i = 0; i < 3; i++) do_line(0);
    checks++;
    if (cut1 !== 8'h00 || lk1 !== 1'b0 || obs !== expv()) begin
      failures++;
      $display("FAIL reenable_mid cut=%h want=00", cut1);
    end
    frame_start();
    do_line(0);
    checks++;
    if (cut1 !== 8'h2A || obs !== expv()) begin
      failures++;
      $display("FAIL reenable_frame cut=%h want=2A", cut1);
    end
  endtask

  task automatic test_saturation();
    load_key($urandom | 32'h1);
    frame_start();
    for (int i = 0; i < 1030; i++) begin
      V = 0; H = 1; tick();
      H = 0; tick();
    end
    checks++;
    if (line1 !== 10'h3FF || obs !== expv()) begin
      failures++;
      $display("FAIL saturate idx=%0d want=1023", line1);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      reset_n  = ($urandom_range(0, 399) != 0);
      enable   = ($urandom_range(0, 59) != 0);
      key_load = ($urandom_range(0, 119) == 0);
      key = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      if ($urandom_range(0, 2) == 0) H = ~H;
      if ($urandom_range(0, 39) == 0) F = ~F;
      if ($urandom_range(0, 19) == 0) V = ~V;
      tick();
      checks++;
      if (obs !== expv()) begin
        failures++;
        $display("FAIL random cyc=%0d got=%h want=%h",
                 c, obs, expv());
      end
    end
  endtask

  initial begin
    test_reset();
    test_keyed_sequence();
    test_vblank();
    test_frame_reseed();
    test_zero_key();
    test_enable_drop();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cut_position_scheduler.md
Name: cut_position_scheduler

Overview:
Generates the per-line raw cut position that drives line_rotator, from a keyed 32-bit Galois LFSR. Stepped once per active video line, using H/V/F from sync_parser. Reseeded from the key at every frame start, so a descrambler with the same key reproduces the identical sequence. Sits between sync_parser and line_rotator.raw_cut_position.

Parameters:
LFSR_WIDTH, 32, LFSR and key width.
CUT_WIDTH, 8, width of raw_cut_position; taken from the LFSR LSBs.
LFSR_TAPS, 32'h80200003, Galois feedback mask (right-shifting form).
RESEED_EACH_FRAME, 1, 1 = reload the LFSR from the key at every frame start; 0 = reload only on leaving WAIT_FRAME.
LINE_IDX_WIDTH, 10, width of line_index.

Ports:
clk  in  1  system clock (pixel clock).
reset_n  in  1  synchronous, active-low reset.
enable  in  1  level; 0 forces identity rotation (cut 0).
key  in  LFSR_WIDTH  scrambling key.
key_load  in  1  1-cycle pulse; latches key.
H  in  1  horizontal blanking flag from sync_parser.
V  in  1  vertical blanking flag from sync_parser.
F  in  1  field flag from sync_parser.
raw_cut_position  out  CUT_WIDTH  cut position to line_rotator.
line_index  out  LINE_IDX_WIDTH  active lines since frame start, saturating.
frame_sync  out  1  1-cycle pulse when the LFSR is (re)seeded.
locked  out  1  1 while state is ACTIVE.

Behaviour:
- Reset: raw_cut_position=0, line_index=0, frame_sync=0, locked=0, key_reg=1, key_valid=0, lfsr=1, prev_H/prev_V/prev_F=0, state=IDLE.
- Edge detect, combinational on the current input vs its registered copy:
  - h_rise = H & !prev_H
  - f_fall = !F & prev_F (frame start)
  - prev_* update every cycle, including in IDLE.
- Key load:
  - key_load in any state: key_reg <= (key==0 ? 1 : key), key_valid <= 1.
  - If enable=1, state -> WAIT_FRAME the same edge. This also applies when already ACTIVE, so the new key takes effect at the next frame start.
  - key_load has priority over every other event that cycle.
- State IDLE:
  - raw_cut_position held 0, locked 0.
  - Go to WAIT_FRAME when enable=1 and key_valid=1.
- State WAIT_FRAME:
  - raw_cut_position held 0.
  - On f_fall: lfsr <= key_reg, line_index <= 0, frame_sync=1 for one cycle, state -> ACTIVE.
  - H edges are ignored in this state.
- State ACTIVE, h_rise & !V:
  - raw_cut_position <= lfsr[CUT_WIDTH-1:0].
  - lfsr <= lfsr[0] ? (lfsr>>1) ^ LFSR_TAPS : lfsr>>1.
  - line_index <= line_index+1, saturating at all-ones.
  - New value is visible the cycle after h_rise is sampled and is held for the whole line (1-cycle latency).
- State ACTIVE, h_rise & V: no change; the cut is held through vertical blanking.
- State ACTIVE, f_fall:
  - RESEED_EACH_FRAME=1: lfsr <= key_reg, line_index <= 0, frame_sync pulse.
  - RESEED_EACH_FRAME=0: line_index <= 0 only.
- Simultaneous f_fall and h_rise: reseed wins and the cut update is skipped for that edge.
- enable=0 in any state: at the next edge state -> IDLE, raw_cut_position <= 0, locked <= 0. The LFSR is frozen, key_reg is retained, and there is no partial-line glitch beyond that cycle.
- enable 0->1 with key_valid=1: IDLE -> WAIT_FRAME. The sequence restarts only at the next frame start, never mid-frame.
- reset_n low mid-frame: full reset values at the next edge, key_valid cleared.
- LFSR never reaches 0, because key 0 is substituted by 1.
- locked = (state==ACTIVE), registered.

Test Plan:
- Reset: hold reset_n=0 for 4 clocks with H/V/F toggling -> all outputs 0, state IDLE; enable=1 without key_load -> stays IDLE, raw_cut_position=0.
- Keyed sequence:
  - Stimulus: key=32'h0000002A, key_load pulse, enable=1, F 1->0, then three active lines (V=0).
  - Response: frame_sync 1 cycle after the F fall; locked=1.
  - Cuts 8'h2A, 8'h15, 8'h09 (LFSR 2A->15->80200009), each visible 1 cycle after its H rise.
  - line_index 1, 2, 3.
- Vertical blanking: five H rises with V=1 inside ACTIVE -> raw_cut_position and line_index unchanged.
- Frame reseed: second F 1->0 after arbitrary lines -> first active cut is again 8'h2A and line_index restarts at 1. With RESEED_EACH_FRAME=0 the sequence continues instead.
- Zero key: key=0, key_load, frame start, one active line -> raw_cut_position=8'h01.
- Enable drop mid-frame: enable=0 on line 10 -> raw_cut_position=0 and locked=0 next cycle. Re-enable mid-frame -> cut stays 0 until the next F fall, then 8'h2A.
